instr_fetch: RTL
================

// Module: instr_fetch
// PURPOSE
//  Fetch initiator for the instruction RAM. Owns the PC, drives iram address/read_not_write,
//  captures the registered read word one cycle later and presents it to decode over
//  valid/ready. Sits between iram and the decode stage.
//  Holds a 2-entry buffer so a stalled decode loses no fetched word.
//  Accepts a redirect (branch/jump) that flushes everything in flight.
// PARAMETERS
//  ADDRESS_BUS_WIDTH  24  width of PC / iram address
//  INSTRUCTION_WIDTH  33  width of one instruction word
//  PC_RESET           0   PC value loaded on reset
// PORTS
//  clk                 in   1      clock, all state on posedge
//  rst                 in   1      asynchronous, active-high reset
//  run                 in   1      1 = fetching allowed; 0 = issue no new reads
//  iram_address        out  AW     word address to iram
//  iram_read_not_write out  1      constant 1 (fetch never writes iram)
//  iram_data           in   IW     iram read data, valid 1 cycle after address sampled
//  instr_valid         out  1      instr/instr_pc hold a valid fetched word
//  instr               out  IW     fetched instruction (buffer head)
//  instr_pc            out  AW     address the word was fetched from
//  instr_ready         in   1      decode accepts head when instr_valid & instr_ready
//  redirect_valid      in   1      flush and restart fetch at redirect_pc
//  redirect_pc         in   AW     new fetch address
// BEHAVIOUR
//  Reset (async, immediate): pc=PC_RESET, buffer empty, in-flight cleared; instr_valid=0,
//   instr=0, instr_pc=0, iram_address=PC_RESET, iram_read_not_write=1 (also during reset).
//  Issue: cycle N issues a read when run=1 & redirect_valid=0 & (count + inflight) < 2.
//   iram_address=pc combinationally from pc reg; on issue pc <= pc+1, inflight <= 1 with
//   captured issue address. No issue -> pc holds; iram_address still shows pc.
//  Return: word appears on iram_data in cycle N+1; written into buffer at end of N+1 if the
//   in-flight read was not squashed. instr_valid earliest in N+2 (issue-to-valid = 2 cycles).
//   Steady state with instr_ready=1: one instruction per cycle, no bubbles.
//  Buffer: 2-entry FIFO of {instr_pc, instr}; head on outputs; pop on valid&ready.
//   Credit rule (count+inflight<2) guarantees no overflow; push+pop same cycle allowed.
//   instr/instr_pc hold last value when empty (don't-care, instr_valid=0).
//  Redirect (redirect_valid=1 in cycle R): buffer emptied, in-flight read squashed (its
//   data in R+1 discarded), pc <= redirect_pc, no issue in R. First read of redirect_pc
//   issued R+1, its instr_valid earliest R+3. Redirect wins over push and pop in R;
//   a head accepted in R (valid&ready) still counts as consumed by decode.
//   Back-to-back redirects: last one wins.
//  run=0: no new issue; an in-flight read still lands; buffer still drains to decode.
//  PC arithmetic: unsigned, modulo 2^ADDRESS_BUS_WIDTH (all-ones + 1 -> 0), no flag.
//  Reset mid-operation: in-flight data returning after rst deassert is discarded.
// TESTING
//  1 rst, run=1, ready=1, iram words[k]=k+100 -> instr_valid from cycle 2, instr_pc 0,1,2...
//    one per cycle, instr=100,101,102...
//  2 ready=0 for 5 cycles mid-stream -> exactly 2 words buffered, at most 1 more address
//    issued, no word lost/duplicated after ready=1; order preserved.
//  3 redirect_valid=1, redirect_pc=0x20 while buffer full + read in flight -> instr_valid=0
//    next cycle, stale words never presented, first word instr_pc=0x20 two cycles later.
//  4 redirect same cycle as valid&ready -> head consumed once, nothing else stale appears.
//  5 PC_RESET=all-ones (AW=24): pc 0xFFFFFF then 0x000000; iram_read_not_write=1 throughout.
//  6 assert rst with buffer full + read in flight -> outputs at reset values immediately;
//    after release fetch restarts at PC_RESET with no stale word.

Source files
------------

// File: rtl/instr_fetch_if.sv
// instr_fetch_if: iram port plus the decode valid/ready and redirect signals of the fetch stage.
interface instr_fetch_if #(
  parameter int ADDRESS_BUS_WIDTH = 24,
  parameter int INSTRUCTION_WIDTH = 33
);
  logic                         run;
  logic [ADDRESS_BUS_WIDTH-1:0] iram_address;
  logic                         iram_read_not_write;
  logic [INSTRUCTION_WIDTH-1:0] iram_data;
  logic                         instr_valid;
  logic [INSTRUCTION_WIDTH-1:0] instr;
  logic [ADDRESS_BUS_WIDTH-1:0] instr_pc;
  logic                         instr_ready;
  logic                         redirect_valid;
  logic [ADDRESS_BUS_WIDTH-1:0] redirect_pc;
  modport master (
    input  run, iram_data, instr_ready, redirect_valid, redirect_pc,
    output iram_address, iram_read_not_write, instr_valid, instr, instr_pc
  );
  modport slave (
    output run, iram_data, instr_ready, redirect_valid, redirect_pc,
    input  iram_address, iram_read_not_write, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner issuing iram reads and queueing returned words in a 2-entry buffer for decode.
module instr_fetch #(
  parameter int                           ADDRESS_BUS_WIDTH = 24,
  parameter int                           INSTRUCTION_WIDTH = 33,
  parameter logic [ADDRESS_BUS_WIDTH-1:0] PC_RESET          = '0
) (
  input logic            clk,
  input logic            rst,
  instr_fetch_if.master  bus
);
  localparam int AW = ADDRESS_BUS_WIDTH;
  localparam int IW = INSTRUCTION_WIDTH;
  logic [AW-1:0] r_pc, r_fl_pc, r_b0_pc, r_b1_pc;
  logic [IW-1:0] r_b0, r_b1;
  logic          r_inflight;
  logic [1:0]    r_count;
  logic          w_pop, w_issue;
  logic [1:0]    w_after;
  // Credit uses occupancy after this cycle's pop so a draining decode sees no bubbles.
  always_comb begin
    w_pop   = (r_count != 2'd0) && bus.instr_ready;
    w_after = r_count - {1'b0, w_pop};
    w_issue = bus.run && !bus.redirect_valid && ((w_after + {1'b0, r_inflight}) < 2'd2);
  end
  assign bus.iram_address        = r_pc;
  assign bus.iram_read_not_write = 1'b1;
  assign bus.instr_valid         = r_count != 2'd0;
  assign bus.instr               = r_b0;
  assign bus.instr_pc            = r_b0_pc;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc       <= PC_RESET;
      r_fl_pc    <= '0;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
      r_b0       <= '0;
      r_b0_pc    <= '0;
      r_b1       <= '0;
      r_b1_pc    <= '0;
    end else if (bus.redirect_valid) begin
      r_pc       <= bus.redirect_pc;
      r_inflight <= 1'b0;
      r_count    <= 2'd0;
    end else begin
      r_pc       <= w_issue ? r_pc + AW'(1) : r_pc;
      r_fl_pc    <= w_issue ? r_pc : r_fl_pc;
      r_inflight <= w_issue;
      r_count    <= w_after + {1'b0, r_inflight};
      r_b0       <= (r_inflight && w_after == 2'd0) ? bus.iram_data :
                    (w_pop && r_count == 2'd2) ? r_b1 : r_b0;
      r_b0_pc    <= (r_inflight && w_after == 2'd0) ? r_fl_pc :
                    (w_pop && r_count == 2'd2) ? r_b1_pc : r_b0_pc;
      r_b1       <= (r_inflight && w_after == 2'd1) ? bus.iram_data : r_b1;
      r_b1_pc    <= (r_inflight && w_after == 2'd1) ? r_fl_pc : r_b1_pc;
    end
  end
endmodule
